// File: rtl/bocks_vga_pkg.sv
// Shared 640x400@70Hz VGA timing, framebuffer geometry and scanout pipeline types.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bocks_vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  // Vertical timing, in lines
  localparam int unsigned V_ACTIVE = 400;
  localparam int unsigned V_FP     = 12;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 35;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 449

  // Sync windows, inclusive counter values
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;               // 656
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;     // 751
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;               // 412
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;     // 413

  // Framebuffer geometry
  localparam int unsigned PIXEL_COUNT = H_ACTIVE * V_ACTIVE;            // 256000
  localparam int unsigned ADDR_W      = 18;
  localparam int unsigned PIX_W       = 8;

  // Control bits that travel alongside the pixel through the scanout pipeline
  typedef struct packed {
    logic hs;   // hsync, active low
    logic vs;   // vsync, active high
    logic hb;   // horizontal blank
    logic vb;   // vertical blank
    logic de;   // data enable
    logic fs;   // first pixel of frame
  } vid_ctl_t;

  // Idle/reset state of the control bits: syncs inactive, fully blanked
  localparam vid_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b0, hb: 1'b1, vb: 1'b1, de: 1'b0, fs: 1'b0};

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port framebuffer RAM, one write port and one registered read port.
// Latency: 1 clock read; a same-address read and write returns the old data.
// Backpressure: none; both ports operate every cycle.
module fb_ram_dp
  import bocks_vga_pkg::*;
#(
  parameter int unsigned DEPTH = PIXEL_COUNT,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned DW    = PIX_W
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // No reset on the array so contents survive a scanout reset
  logic [DW-1:0] mem_q [DEPTH];

  // Write and registered read share one edge; the read samples pre-write contents
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: greyscale RAM written by the renderer, scanned out as VGA r=g=b.
// Latency: 2 pclk from counter position to pixel, sync, blank, DE and frame_start outputs.
// Backpressure: none; writes accepted every cycle, addresses outside the framebuffer dropped.
module vga_fb_scanout
  import bocks_vga_pkg::*;
#(
  parameter int unsigned HACT = H_ACTIVE,
  parameter int unsigned HFP  = H_FP,
  parameter int unsigned HSW  = H_SYNC,
  parameter int unsigned HBP  = H_BP,
  parameter int unsigned VACT = V_ACTIVE,
  parameter int unsigned VFP  = V_FP,
  parameter int unsigned VSW  = V_SYNC,
  parameter int unsigned VBP  = V_BP
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic        hs,
  output logic        vs,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        VGA_HB,
  output logic        VGA_VB,
  output logic        VGA_DE,
  output logic        frame_start
);

  localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSW + VBP;
  localparam int unsigned PIX  = HACT * VACT;
  localparam int unsigned AW   = $clog2(PIX);
  localparam int unsigned HCW  = $clog2(HTOT);
  localparam int unsigned VCW  = $clog2(VTOT);

  localparam logic [HCW-1:0] H_LAST   = HCW'(HTOT - 1);
  localparam logic [HCW-1:0] H_ACT_L  = HCW'(HACT);
  localparam logic [HCW-1:0] HS_START = HCW'(HACT + HFP);
  localparam logic [HCW-1:0] HS_END   = HCW'(HACT + HFP + HSW - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(VTOT - 1);
  localparam logic [VCW-1:0] V_ACT_L  = VCW'(VACT);
  localparam logic [VCW-1:0] VS_START = VCW'(VACT + VFP);
  localparam logic [VCW-1:0] VS_END   = VCW'(VACT + VFP + VSW - 1);
  localparam logic [AW-1:0]  RD_LAST  = AW'(PIX - 1);

  // Counter stage
  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic [AW-1:0]  rd_addr_q, rd_addr_d;
  logic           active;
  logic           frame_end;

  // Pipeline stages
  vid_ctl_t       ctl_s1_q, ctl_s1_d;
  vid_ctl_t       ctl_s2_q;
  logic [7:0]     pix_q, pix_d;
  logic [7:0]     ram_rdata;

  // Write port qualification
  logic           wr_en;
  logic [AW-1:0]  wr_addr;

  // Next raster position and linear read address; no multiplier, just a running index
  always_comb begin
    h_cnt_d   = h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    rd_addr_d = rd_addr_q;
    active    = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
    frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    if (frame_end) begin
      rd_addr_d = '0;
    end else if (active && (rd_addr_q != RD_LAST)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end
  end

  // Raster counters and read address register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Timing decode at the counter position; enters the pipeline alongside the RAM read
  always_comb begin
    ctl_s1_d    = CTL_IDLE;
    ctl_s1_d.hs = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
    ctl_s1_d.vs = (v_cnt_q >= VS_START) && (v_cnt_q <= VS_END);
    ctl_s1_d.hb = (h_cnt_q >= H_ACT_L);
    ctl_s1_d.vb = (v_cnt_q >= V_ACT_L);
    ctl_s1_d.de = active;
    ctl_s1_d.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Pixel output is forced to black whenever the matching DE is low
  always_comb begin
    pix_d = ctl_s1_q.de ? ram_rdata : 8'h00;
  end

  // Two-stage control delay matching the RAM read plus output register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_s1_q <= CTL_IDLE;
      ctl_s2_q <= CTL_IDLE;
      pix_q    <= '0;
    end else begin
      ctl_s1_q <= ctl_s1_d;
      ctl_s2_q <= ctl_s1_q;
      pix_q    <= pix_d;
    end
  end

  // Full 32-bit compare drops both high garbage bits and the tail past the last pixel;
  // writes are ignored while in reset even though the array itself is not reset
  assign wr_en   = cpu_wr && reset_n && (cpu_addr < 32'(PIX));
  assign wr_addr = cpu_addr[AW-1:0];

  fb_ram_dp #(
    .DEPTH (PIX),
    .AW    (AW),
    .DW    (8)
  ) u_fb_ram (
    .clk_i   (pclk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (cpu_data),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  assign hs          = ctl_s2_q.hs;
  assign vs          = ctl_s2_q.vs;
  assign VGA_HB      = ctl_s2_q.hb;
  assign VGA_VB      = ctl_s2_q.vb;
  assign VGA_DE      = ctl_s2_q.de;
  assign frame_start = ctl_s2_q.fs;
  assign r           = pix_q;
  assign g           = pix_q;
  assign b           = pix_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: full horizontal timing, short frame (4 active lines).
// Stimulus pushes whole-frame expected pixels into a queue; a monitor pops on DE.
// Timing monitor measures hsync, vsync, DE runs and frame_start spacing.
module tb_vga_fb_scanout;

  localparam int unsigned HACT = 640;
  localparam int unsigned HFP  = 16;
  localparam int unsigned HSW  = 96;
  localparam int unsigned HBP  = 48;
  localparam int unsigned VACT = 4;
  localparam int unsigned VFP  = 1;
  localparam int unsigned VSW  = 2;
  localparam int unsigned VBP  = 2;
  localparam int PIX       = 2560;   // 640 * 4
  localparam int LINE_CYC  = 800;
  localparam int FRAME_CYC = 7200;   // 800 * 9
  localparam int TMO       = 8000;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start;
  logic [7:0]  r, g, b;

  vga_fb_scanout #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .hs          (hs),
    .vs          (vs),
    .r           (r),
    .g           (g),
    .b           (b),
    .VGA_HB      (VGA_HB),
    .VGA_VB      (VGA_VB),
    .VGA_DE      (VGA_DE),
    .frame_start (frame_start)
  );

  always #5 pclk = ~pclk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] model [PIX];
  logic [7:0] exp_q [$];
  bit         sb_on = 1'b0;
  bit         tm_on = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One write per cycle; called on a falling edge, returns on the next one
  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    if (a < 32'(PIX)) model[int'(a)] = d;
    @(negedge pclk);
    cpu_wr = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < PIX; i++) exp_q.push_back(model[i]);
  endtask

  task automatic wait_fs(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < TMO && !seen; k++) begin
      @(negedge pclk);
      if (frame_start) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_fs_%s: no frame_start within %0d cycles, required one", tag, TMO);
    end
  endtask

  task automatic wait_vb_rise(input string tag);
    bit   seen = 1'b0;
    logic prev = VGA_VB;
    for (int k = 0; k < TMO && !seen; k++) begin
      @(negedge pclk);
      if (!prev && VGA_VB) seen = 1'b1;
      prev = VGA_VB;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_vb_%s: no VB rise within %0d cycles, required one", tag, TMO);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_hb"}, VGA_HB, 1);
    chk({tag, "_vb"}, VGA_VB, 1);
    chk({tag, "_de"}, VGA_DE, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_rgb"}, {r, g, b}, 24'h0);
  endtask

  // Scoreboard monitor: every DE cycle consumes one expected pixel
  initial begin : scoreboard
    logic [7:0] e;
    logic       de_exp;
    forever begin
      @(negedge pclk);
      if (sb_on) begin
        de_exp = ~(VGA_HB | VGA_VB);
        chk("de_eq_not_blank", VGA_DE, de_exp);
        if (VGA_DE) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pixel_unexpected: got DE=1 rgb=0x%0h, required no pixel (queue empty)", r);
          end else begin
            e = exp_q.pop_front();
            chk("pixel_r", r, e);
            chk("pixel_g", g, e);
            chk("pixel_b", b, e);
          end
        end else begin
          chk("rgb_blank", {r, g, b}, 24'h0);
        end
      end
    end
  end

  // Timing monitor: edge-to-edge measurements in pixel clocks
  initial begin : timing_mon
    logic hs_p = 1'b1, de_p = 1'b0, vs_p = 1'b0, fs_p = 1'b0;
    bit   have_fall = 0, in_low = 0, in_run = 0, in_vs = 0, have_fs = 0;
    int   last_fall = 0, hs_low = 0, de_run = 0, vs_hi = 0, last_fs = 0, lines = 0;
    forever begin
      @(negedge pclk);
      if (!tm_on) begin
        have_fall = 0; in_low = 0; in_run = 0; in_vs = 0; have_fs = 0;
      end else begin
        if (hs_p && !hs) begin
          if (have_fall) chk("hs_period", 32'(cyc - last_fall), LINE_CYC);
          last_fall = cyc; have_fall = 1; in_low = 1; hs_low = 0;
        end
        if (!hs_p && hs && in_low) chk("hs_low_width", hs_low, HSW);
        if (!hs) hs_low++;

        if (!de_p && VGA_DE) begin in_run = 1; de_run = 0; end
        if (de_p && !VGA_DE && in_run) begin
          chk("de_run_len", de_run, HACT);
          lines++;
        end
        if (VGA_DE) de_run++;

        if (!vs_p && vs) begin in_vs = 1; vs_hi = 0; end
        if (vs_p && !vs && in_vs) chk("vs_high_cycles", vs_hi, VSW * LINE_CYC);
        if (vs) vs_hi++;

        if (fs_p) chk("fs_one_cycle", frame_start, 0);
        if (frame_start) begin
          chk("fs_with_de", VGA_DE, 1);
          chk("fs_prev_de_low", de_p, 0);
          if (have_fs) begin
            chk("fs_period", 32'(cyc - last_fs), FRAME_CYC);
            chk("lines_per_frame", lines, VACT);
          end
          last_fs = cyc; have_fs = 1; lines = 0;
        end
      end
      hs_p = hs; de_p = VGA_DE; vs_p = vs; fs_p = frame_start;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge pclk);
    $display("FAIL watchdog: still running after 60000 cycles, required to finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin : stim
    reset_n  = 1'b0;
    cpu_wr   = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    repeat (2) @(negedge pclk);
    chk_reset_outs("por");
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    @(negedge pclk);
    chk("por_de_1clk", VGA_DE, 0);
    @(negedge pclk);
    chk("por_de_2clk", VGA_DE, 1);
    chk("por_fs_2clk", frame_start, 1);

    // Frame A: contents unknown; fill the whole buffer in its vertical blank
    wait_vb_rise("A");
    for (int i = 0; i < PIX; i++) wr(32'(i), 8'(i * 7 + 3));
    push_frame();
    sb_on = 1'b1;
    tm_on = 1'b1;

    // Frame B shows the fill; corner writes land in frame C
    wait_fs("B");
    wait_vb_rise("B");
    wr(32'd0,         8'hA5);
    wr(32'd639,       8'h3C);
    wr(32'd640,       8'hFF);
    wr(32'(PIX - 1),  8'h11);
    push_frame();

    // Frame C; out-of-range writes must leave frame D identical
    wait_fs("C");
    wait_vb_rise("C");
    wr(32'd256000,       8'h77);
    wr(32'h0004_0000,    8'h77);
    wr(32'(PIX),         8'h77);
    wr(32'h0000_1003,    8'h77);
    wr(32'hFFFF_FFFF,    8'h77);
    push_frame();

    // Frame D: write pixel 100 in the very cycle it is being read (old value expected now)
    wait_fs("D");
    repeat (98) @(negedge pclk);
    wr(32'd100, 8'h55);
    wait_vb_rise("D");
    push_frame();

    // Frame E: 0x55 visible; then reset mid-line at raster (300, 2)
    wait_fs("E");
    repeat (2 * LINE_CYC + 298) @(negedge pclk);
    #2;
    tm_on   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outs("mid_async");
    cpu_wr   = 1'b1;
    cpu_addr = 32'd5;
    cpu_data = 8'hEE;
    repeat (3) @(negedge pclk);
    cpu_wr = 1'b0;
    chk_reset_outs("mid_hold");
    exp_q.delete();
    push_frame();
    reset_n = 1'b1;
    @(negedge pclk);
    chk("mid_de_1clk", VGA_DE, 0);
    @(negedge pclk);
    chk("mid_de_2clk", VGA_DE, 1);
    chk("mid_fs_2clk", frame_start, 1);

    // Frame F: full readback after reset, RAM intact and reset-time write ignored
    wait_vb_rise("F");
    repeat (4) @(negedge pclk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Downstream stage of the font/text renderer. It accepts the renderer's pixel-write stream (cpu_wr/cpu_addr/cpu_data) into a 640x400 8-bit greyscale framebuffer. It generates 640x400@70Hz VGA timing and scans the framebuffer out as r=g=b, with sync, blank and DE signals aligned to the pixel data. It also emits a frame_start pulse so upstream stages can pace redraws.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_ACTIVE, 400, visible lines
V_FP, 12, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 35, vertical back porch (lines); V_TOTAL = 449
PIXEL_COUNT, 256000, framebuffer depth (H_ACTIVE*V_ACTIVE)

Ports:
pclk  in  1  pixel clock (25.175 MHz), sole clock
reset_n  in  1  asynchronous, active-low reset
cpu_wr  in  1  framebuffer write strobe
cpu_addr  in  32  linear pixel address (y*640 + x)
cpu_data  in  8  greyscale pixel value
hs  out  1  hsync, active low
vs  out  1  vsync, active high
r  out  8  red
g  out  8  green
b  out  8  blue
VGA_HB  out  1  horizontal blank, high outside active columns
VGA_VB  out  1  vertical blank, high outside active lines
VGA_DE  out  1  data enable = ~(HB|VB)
frame_start  out  1  one-cycle pulse, aligned with first active pixel of a frame

Behaviour:
- Reset is asynchronous and active-low, one clock pclk. While reset_n=0:
  - h_cnt=0, v_cnt=0, rd_addr=0.
  - Outputs: hs=1, vs=0, r/g/b=0, VGA_HB=1, VGA_VB=1, VGA_DE=0, frame_start=0.
  - cpu_wr is ignored.
  - RAM contents are preserved, not cleared.
- After release, scan restarts at (h=0, v=0). Reset mid-frame truncates the frame with no glitch pulses beyond the reset values.
- Counters:
  - h_cnt runs 0..799 and wraps.
  - v_cnt increments when h_cnt=799 and wraps after 448.
- Timing decode at counter stage, (h, v):
  - active = h<640 && v<400.
  - hsync asserted for 656 <= h <= 751.
  - vsync asserted for 412 <= v <= 413.
  - HB = h>=640; VB = v>=400.
- Read address:
  - rd_addr increments by 1 on each active cycle, saturating the increment at 255999.
  - rd_addr returns to 0 when h=799 && v=448.
  - No multiplier is used.
- Pipeline: 2 cycles.
  - Stage 1: RAM read at rd_addr (registered read).
  - Stage 2: output register.
  - hs/vs/HB/VB/DE/frame_start are delayed through a matching 2-stage shift so all outputs are aligned.
  - r=g=b = RAM data when delayed DE=1, else 0.
- frame_start: decoded at (h=0, v=0); after the pipeline it is high in the same cycle as the first visible pixel of the frame.
- Write port:
  - On each cycle with cpu_wr=1 and cpu_addr < PIXEL_COUNT, RAM[cpu_addr[17:0]] <= cpu_data.
  - Addresses >= PIXEL_COUNT, including any nonzero bit in [31:18], are dropped silently.
  - Writes are accepted every cycle with no backpressure.
- Simultaneous read and write to the same address: read-before-write. The scan returns the old value; the new value appears on the next frame.
- Write and read are independent ports (simple dual-port RAM, one clock).

Decomposition:
- Package bocks_vga_pkg holds:
  - the timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - the derived sync start/end values;
  - PIXEL_COUNT and the address width (18).
- One sub-module, fb_ram_dp: simple dual-port RAM of 256000x8 with a registered read and read-before-write semantics, inferred as block RAM.

Test Plan:
- Hold reset_n=0 for 5 cycles, then release -> during reset hs=1, vs=0, DE=0, HB=VB=1, rgb=0. First DE=1 occurs 2 cycles after release, together with frame_start=1.
- Free-run 2 frames -> exactly 800 clocks between hs falling edges, hs low for 96 clocks, and 449*800 = 359200 clocks between frame_start pulses. Per line, DE is high for 640 consecutive cycles, and there are 400 such lines per frame.
- Write 8'hA5 at addr 0, 8'h3C at 639, 8'hFF at 640 and 8'h11 at 255999 -> next frame r=g=b=A5 at pixel (0,0), 3C at (639,0), FF at (0,1) and 11 at (639,399). Every other pixel keeps its prior value.
- Write 8'h77 at addr 256000 and at 32'h0004_0000 -> no RAM location changes; a full-frame readback matches the pre-write contents.
- Write 8'h55 at address N exactly in the cycle rd_addr=N -> the current frame shows the old value at N and the following frame shows 55.
- Assert reset_n=0 mid-line at (h=300, v=200) for 3 cycles -> outputs go to reset values asynchronously. After release the frame restarts at (0,0) with frame_start, and RAM contents are intact.
